// File: rtl/uart_word_packer.sv
// Packs UART RX bytes (header + WIDTH_DOUT/8 payload bytes) into one coprocessor word per frame.
// Optional trailing XOR checksum byte when PACKER_CHECKSUM_EN is defined.
module uart_word_packer #(
  parameter int unsigned WIDTH_DOUT     = 128,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [WIDTH_DOUT-1:0] dout,
  output logic                  dout_valid,
  output logic [5:0]            control,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned NBYTES = WIDTH_DOUT / 8;
  localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned TMR_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

`ifdef PACKER_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_CHECK} state_t;
  logic [7:0] csum;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD} state_t;
`endif

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [TMR_W-1:0]      timer;
  logic [WIDTH_DOUT-1:0] shreg;
  logic [5:0]            pend_ctrl;
  logic                  emit_pend;
  logic                  timeout_c;
  logic                  last_byte_c;

  // Timeout fires once the idle count inside a frame reaches the limit.
  assign timeout_c   = (TIMEOUT_CYCLES != 0) && (state != ST_IDLE) &&
                       (timer == TMR_W'(TIMEOUT_CYCLES));
  assign last_byte_c = (cnt == CNT_W'(NBYTES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      timer      <= '0;
      shreg      <= '0;
      pend_ctrl  <= '0;
      emit_pend  <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      control    <= '0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef PACKER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      emit_pend  <= 1'b0;

      // Publish a completed frame one edge after its final byte was accepted.
      if (emit_pend) begin
        dout       <= shreg;
        control    <= pend_ctrl;
        dout_valid <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (rx_valid && (rx_data[7:6] == 2'b10)) begin
            pend_ctrl <= rx_data[5:0];
            cnt       <= '0;
            timer     <= '0;
            state     <= ST_PAYLOAD;
            busy      <= 1'b1;
`ifdef PACKER_CHECKSUM_EN
            csum      <= rx_data;
`endif
          end
        end

        ST_PAYLOAD: begin
          if (timeout_c) begin
            frame_err <= 1'b1;
            shreg     <= '0;
            cnt       <= '0;
            timer     <= '0;
            state     <= ST_IDLE;
            busy      <= 1'b0;
          end else if (rx_valid) begin
            shreg <= WIDTH_DOUT'({shreg, rx_data});
            timer <= '0;
            cnt   <= cnt + 1'b1;
`ifdef PACKER_CHECKSUM_EN
            csum  <= csum ^ rx_data;
            if (last_byte_c) begin
              cnt   <= '0;
              state <= ST_CHECK;
            end
`else
            if (last_byte_c) begin
              cnt       <= '0;
              state     <= ST_IDLE;
              busy      <= 1'b0;
              emit_pend <= 1'b1;
            end
`endif
          end else if (TIMEOUT_CYCLES != 0) begin
            timer <= timer + 1'b1;
          end
        end

`ifdef PACKER_CHECKSUM_EN
        ST_CHECK: begin
          if (timeout_c) begin
            frame_err <= 1'b1;
            shreg     <= '0;
            timer     <= '0;
            state     <= ST_IDLE;
            busy      <= 1'b0;
          end else if (rx_valid) begin
            timer <= '0;
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (rx_data == csum) begin
              emit_pend <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else if (TIMEOUT_CYCLES != 0) begin
            timer <= timer + 1'b1;
          end
        end
`endif

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
